// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Per-button 2-flop synchronizer, counter debouncer and
//               rising-edge one-shot feeding bicycle_fsm (faster/slower/next).
//               Optional feature macro: AUTO_REPEAT_EN (held-button repeat).
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int                   N_BUTTONS       = 3,
    parameter int                   DEBOUNCE_CYCLES = 250000,
    parameter int                   CNT_W           = $clog2(DEBOUNCE_CYCLES),
    parameter int                   REPEAT_DELAY    = 50000000,
    parameter int                   REPEAT_PERIOD   = 12500000,
    parameter logic [N_BUTTONS-1:0] REPEAT_MASK     = 3'b011
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_BUTTONS-1:0] btn_raw,
    output logic [N_BUTTONS-1:0] btn_level,
    output logic [N_BUTTONS-1:0] btn_pulse
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef AUTO_REPEAT_EN
    localparam int c_RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_RPT_W   = $clog2(c_RPT_MAX + 1);
    localparam logic [c_RPT_W-1:0] c_RPT_DELAY_LAST  = c_RPT_W'(REPEAT_DELAY - 1);
    localparam logic [c_RPT_W-1:0] c_RPT_PERIOD_LAST = c_RPT_W'(REPEAT_PERIOD - 1);
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{REPEAT_MASK, REPEAT_DELAY[0], REPEAT_PERIOD[0]};
`endif

    genvar i;
    generate
        for (i = 0; i < N_BUTTONS; i++) begin : g_chan
            logic             r_sync1;
            logic             r_sync2;
            logic             r_level;
            logic             r_pulse;
            logic [CNT_W-1:0] r_cnt;
            logic             w_differs;
            logic             w_terminal;
            logic             w_press;
            logic             w_repeat;

            assign w_differs  = r_sync2 ^ r_level;
            assign w_terminal = w_differs && (r_cnt == c_CNT_LAST);
            assign w_press    = w_terminal && r_sync2;

            // The pulse is registered on the same edge the level rises so both appear together.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                    r_level <= 1'b0;
                    r_pulse <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_sync1 <= btn_raw[i];
                    r_sync2 <= r_sync1;
                    if (!w_differs) begin
                        r_cnt <= '0;
                    end else if (w_terminal) begin
                        r_cnt   <= '0;
                        r_level <= r_sync2;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    r_pulse <= w_press || w_repeat;
                end
            end

`ifdef AUTO_REPEAT_EN
            if (REPEAT_MASK[i]) begin : g_repeat
                logic [c_RPT_W-1:0] r_rpt_cnt;
                logic               r_rpt_active;
                logic               r_rpt_periodic;
                logic [c_RPT_W-1:0] w_rpt_target;
                logic               w_release;
                logic               w_rpt_hit;

                assign w_release    = w_terminal && !r_sync2;
                assign w_rpt_target = r_rpt_periodic ? c_RPT_PERIOD_LAST : c_RPT_DELAY_LAST;
                // A release on the same edge wins: no repeat pulse as the button lets go.
                assign w_rpt_hit    = r_rpt_active && !w_release && (r_rpt_cnt == w_rpt_target);
                assign w_repeat     = w_rpt_hit;

                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        r_rpt_cnt      <= '0;
                        r_rpt_active   <= 1'b0;
                        r_rpt_periodic <= 1'b0;
                    end else if (w_press) begin
                        r_rpt_cnt      <= '0;
                        r_rpt_active   <= 1'b1;
                        r_rpt_periodic <= 1'b0;
                    end else if (w_release) begin
                        r_rpt_cnt      <= '0;
                        r_rpt_active   <= 1'b0;
                        r_rpt_periodic <= 1'b0;
                    end else if (w_rpt_hit) begin
                        r_rpt_cnt      <= '0;
                        r_rpt_periodic <= 1'b1;
                    end else if (r_rpt_active) begin
                        r_rpt_cnt <= r_rpt_cnt + 1'b1;
                    end
                end
            end else begin : g_no_repeat
                assign w_repeat = 1'b0;
            end
`else
            assign w_repeat = 1'b0;
`endif

            assign btn_level[i] = r_level;
            assign btn_pulse[i] = r_pulse;
        end
    endgenerate

endmodule
`default_nettype wire
